// File: rtl/imem_loader_pkg.sv
// Shared loader definitions: FSM state encoding, default frame magic and imem depth helper.
// Imported by the loader top and its byte-lane assembler.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    LDR_IDLE  = 3'd0,
    LDR_LEN0  = 3'd1,
    LDR_LEN1  = 3'd2,
    LDR_DATA  = 3'd3,
    LDR_CSUM  = 3'd4,
    LDR_DONE  = 3'd5,
    LDR_ERROR = 3'd6
  } ldr_state_t;

  localparam logic [7:0] LDR_MAGIC     = 8'hA5;
  localparam int         LDR_DBITS     = 32;
  localparam int         LDR_ADDR_BITS = 11;

  // Capacity in words, widened to 17 bits so a full-depth LEN is representable.
  function automatic logic [16:0] ldr_depth(input int addr_bits);
    return 17'd1 << addr_bits;
  endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Byte-lane shifter: collects 4 little-endian bytes; word_ready/word are combinational on the 4th byte.
// No backpressure of its own; the caller's byte_en gates every transfer.
module word_assembler (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        word_ready,
  output logic [31:0] word
);

  logic [1:0]  byte_idx;
  logic [23:0] lanes;

  // The 4th byte is never stored; it goes straight into the top lane of the output word.
  assign word_ready = byte_en && (byte_idx == 2'd3);
  assign word       = {byte_in, lanes};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_idx <= 2'd0;
      lanes    <= 24'd0;
    end else if (clear) begin
      byte_idx <= 2'd0;
    end else if (byte_en) begin
      byte_idx <= byte_idx + 2'd1;
      case (byte_idx)
        2'd0:    lanes[7:0]   <= byte_in;
        2'd1:    lanes[15:8]  <= byte_in;
        2'd2:    lanes[23:16] <= byte_in;
        default: lanes        <= lanes;
      endcase
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses MAGIC/LEN/words/CSUM frames into imem writes, one cycle after each 4th byte.
// byte_ready is high from IDLE through CSUM (no stalls), low in DONE/ERROR until rearm.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         DBITS          = LDR_DBITS,
  parameter int         IMEM_ADDR_BITS = LDR_ADDR_BITS,
  parameter logic [7:0] MAGIC          = LDR_MAGIC
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [7:0]                byte_in,
  input  logic                      byte_valid,
  output logic                      byte_ready,
  input  logic                      rearm,
  output logic                      imem_we,
  output logic [IMEM_ADDR_BITS-1:0] imem_addr,
  output logic [DBITS-1:0]          imem_wdata,
  output logic                      cpu_hold,
  output logic                      done,
  output logic                      error
);

  localparam logic [16:0] DEPTH = ldr_depth(IMEM_ADDR_BITS);

  ldr_state_t  state;
  logic [16:0] word_cnt;
  logic [16:0] word_cnt_nxt;
  logic [15:0] len;
  logic [7:0]  len_lo;
  logic [7:0]  csum;
  logic [16:0] len_full;
  logic        accept;
  logic        asm_en;
  logic        asm_clear;
  logic        word_ready;
  logic [31:0] word;

  assign accept       = byte_valid && byte_ready;
  assign asm_en       = accept && (state == LDR_DATA);
  assign asm_clear    = (state != LDR_DATA);
  assign word_cnt_nxt = word_cnt + 17'd1;
  assign len_full     = {1'b0, byte_in, len_lo};

  word_assembler u_asm (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (asm_clear),
    .byte_en    (asm_en),
    .byte_in    (byte_in),
    .word_ready (word_ready),
    .word       (word)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= LDR_IDLE;
      byte_ready <= 1'b1;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      word_cnt   <= '0;
      len        <= '0;
      len_lo     <= '0;
      csum       <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        LDR_IDLE: begin
          if (accept && byte_in == MAGIC) state <= LDR_LEN0;
        end
        LDR_LEN0: begin
          if (accept) begin
            len_lo <= byte_in;
            state  <= LDR_LEN1;
          end
        end
        LDR_LEN1: begin
          if (accept) begin
            len <= {byte_in, len_lo};
            if (len_full > DEPTH) begin
              state      <= LDR_ERROR;
              error      <= 1'b1;
              byte_ready <= 1'b0;
            end else if (len_full == 17'd0) begin
              state <= LDR_CSUM;
            end else begin
              state <= LDR_DATA;
            end
          end
        end
        LDR_DATA: begin
          if (accept) begin
            csum <= csum ^ byte_in;
            if (word_ready) begin
              imem_we    <= 1'b1;
              imem_addr  <= word_cnt[IMEM_ADDR_BITS-1:0];
              imem_wdata <= word;
              word_cnt   <= word_cnt_nxt;
              if (word_cnt_nxt == {1'b0, len}) state <= LDR_CSUM;
            end
          end
        end
        LDR_CSUM: begin
          if (accept) begin
            byte_ready <= 1'b0;
            if (byte_in == csum) begin
              state    <= LDR_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= LDR_ERROR;
              error <= 1'b1;
            end
          end
        end
        LDR_DONE, LDR_ERROR: begin
          if (rearm) begin
            state      <= LDR_IDLE;
            byte_ready <= 1'b1;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            word_cnt   <= '0;
            len        <= '0;
            len_lo     <= '0;
            csum       <= '0;
          end
        end
        default: begin
          state <= LDR_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed-frame bench for imem_loader: a frame-level model predicts writes and final status.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_imem_loader;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [10:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk;
  logic        reset_n;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        rearm;
  logic        imem_we;
  logic [10:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int n_chk  = 0;
  int n_pass = 0;

  wr_t exp_q[$];
  wr_t wr_log[$];
  logic [10:0] last_addr;
  logic [31:0] last_data;
  logic        prev_we;

  imem_loader dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .rearm      (rearm),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Frame-level model: skip junk to MAGIC, read LEN, predict writes, compare checksum.
  task automatic model(input bq_t fr, output bit m_done, output bit m_err);
    int i;
    int len;
    logic [7:0]  cs;
    logic [31:0] w;
    wr_t e;
    i = 0;
    cs = 8'h00;
    m_done = 1'b0;
    m_err = 1'b0;
    while (i < fr.size() && fr[i] != 8'hA5) i++;
    i++;
    len = int'(fr[i]) + 256 * int'(fr[i+1]);
    i += 2;
    if (len > 2048) begin
      m_err = 1'b1;
      return;
    end
    for (int k = 0; k < len; k++) begin
      w = {fr[i+3], fr[i+2], fr[i+1], fr[i]};
      cs = cs ^ fr[i] ^ fr[i+1] ^ fr[i+2] ^ fr[i+3];
      e.addr = 11'(k);
      e.data = w;
      exp_q.push_back(e);
      i += 4;
    end
    if (fr[i] == cs) m_done = 1'b1;
    else m_err = 1'b1;
  endtask

  // Write monitor: every imem_we pulse must match the next predicted write.
  always @(negedge clk) begin
    if (!reset_n) begin
      last_addr = 11'd0;
      last_data = 32'd0;
      prev_we   = 1'b0;
    end else begin
      if (imem_we) begin
        chk("we_single_cycle", {63'd0, prev_we}, 64'd0);
        wr_log.push_back({imem_addr, imem_wdata});
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", imem_addr, imem_wdata);
        end else begin
          chk("wr_addr", {53'd0, imem_addr}, {53'd0, exp_q[0].addr});
          chk("wr_data", {32'd0, imem_wdata}, {32'd0, exp_q[0].data});
          last_addr = exp_q[0].addr;
          last_data = exp_q[0].data;
          void'(exp_q.pop_front());
        end
      end else begin
        chk("addr_hold", {53'd0, imem_addr}, {53'd0, last_addr});
        chk("data_hold", {32'd0, imem_wdata}, {32'd0, last_data});
      end
      prev_we = imem_we;
    end
  end

  task automatic send_byte(input logic [7:0] b, inout int stalls);
    int n;
    @(negedge clk);
    byte_in = b;
    byte_valid = 1'b1;
    n = 0;
    while (!byte_ready && n < 20) begin
      stalls++;
      n++;
      @(negedge clk);
    end
    if (!byte_ready) begin
      n_chk++;
      $display("FAIL byte_accept_timeout: byte_ready stayed 0, required 1");
    end
    @(posedge clk);
  endtask

  task automatic run_frame(input string nm, input bq_t fr);
    bit md;
    bit me;
    int stalls;
    model(fr, md, me);
    stalls = 0;
    foreach (fr[k]) send_byte(fr[k], stalls);
    @(negedge clk);
    byte_valid = 1'b0;
    chk({nm, "_done"}, {63'd0, done}, {63'd0, md});
    chk({nm, "_error"}, {63'd0, error}, {63'd0, me});
    chk({nm, "_cpu_hold"}, {63'd0, cpu_hold}, {63'd0, !md});
    chk({nm, "_byte_ready"}, {63'd0, byte_ready}, 64'd0);
    chk({nm, "_stalls"}, 64'(stalls), 64'd0);
    chk({nm, "_writes_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_rearm(input string nm);
    @(negedge clk);
    rearm = 1'b1;
    @(negedge clk);
    rearm = 1'b0;
    chk({nm, "_rearm_error"}, {63'd0, error}, 64'd0);
    chk({nm, "_rearm_done"}, {63'd0, done}, 64'd0);
    chk({nm, "_rearm_ready"}, {63'd0, byte_ready}, 64'd1);
    chk({nm, "_rearm_hold"}, {63'd0, cpu_hold}, 64'd1);
  endtask

  initial begin
    bq_t fr;
    int base;
    int stalls;
    reset_n    = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    rearm      = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    chk("rst_byte_ready", {63'd0, byte_ready}, 64'd1);
    chk("rst_imem_we", {63'd0, imem_we}, 64'd0);
    chk("rst_imem_addr", {53'd0, imem_addr}, 64'd0);
    chk("rst_imem_wdata", {32'd0, imem_wdata}, 64'd0);
    chk("rst_cpu_hold", {63'd0, cpu_hold}, 64'd1);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_error", {63'd0, error}, 64'd0);

    // Good image; XOR of the 8 data bytes is 0x4E.
    base = wr_log.size();
    fr = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h20, 8'h00, 8'h0D, 8'h30, 8'h40, 8'h00, 8'h4E};
    run_frame("good", fr);
    chk("good_nwr", 64'(wr_log.size() - base), 64'd2);
    chk("good_w0", {21'd0, wr_log[base]}, {21'd0, 11'd0, 32'h00200013});
    chk("good_w1", {21'd0, wr_log[base+1]}, {21'd0, 11'd1, 32'h0040300D});
    do_rearm("good");

    // Bad checksum: words still written, then error.
    base = wr_log.size();
    fr = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h20, 8'h00, 8'h0D, 8'h30, 8'h40, 8'h00, 8'h4F};
    run_frame("badcsum", fr);
    chk("badcsum_nwr", 64'(wr_log.size() - base), 64'd2);
    chk("badcsum_error_lit", {63'd0, error}, 64'd1);
    do_rearm("badcsum");

    // Junk before the frame; LEN=1, checksum 11^22^33^44 = 0x44.
    base = wr_log.size();
    fr = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    run_frame("junk", fr);
    chk("junk_w0", {21'd0, wr_log[base]}, {21'd0, 11'd0, 32'h44332211});
    chk("junk_done_lit", {63'd0, done}, 64'd1);
    do_rearm("junk");

    // LEN=0: no writes, checksum of nothing is 0.
    base = wr_log.size();
    fr = '{8'hA5, 8'h00, 8'h00, 8'h00};
    run_frame("len0", fr);
    chk("len0_nwr", 64'(wr_log.size() - base), 64'd0);
    do_rearm("len0");

    // LEN=0x0801 exceeds 2048 words: error right after LEN_HI.
    fr = '{8'hA5, 8'h01, 8'h08};
    run_frame("lenbig", fr);
    chk("lenbig_error_lit", {63'd0, error}, 64'd1);
    do_rearm("lenbig");

    // Back-to-back 3-word frame, bytes 01..0C, checksum 0x0C.
    base = wr_log.size();
    fr = '{8'hA5, 8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
           8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0C};
    run_frame("stream", fr);
    chk("stream_nwr", 64'(wr_log.size() - base), 64'd3);
    chk("stream_w2", {21'd0, wr_log[base+2]}, {21'd0, 11'd2, 32'h0C0B0A09});
    do_rearm("stream");

    // Reset mid-frame after the 2nd data byte.
    stalls = 0;
    send_byte(8'hA5, stalls);
    send_byte(8'h02, stalls);
    send_byte(8'h00, stalls);
    send_byte(8'h11, stalls);
    send_byte(8'h22, stalls);
    @(negedge clk);
    byte_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("midrst_byte_ready", {63'd0, byte_ready}, 64'd1);
    chk("midrst_imem_we", {63'd0, imem_we}, 64'd0);
    chk("midrst_imem_addr", {53'd0, imem_addr}, 64'd0);
    chk("midrst_imem_wdata", {32'd0, imem_wdata}, 64'd0);
    chk("midrst_cpu_hold", {63'd0, cpu_hold}, 64'd1);
    chk("midrst_done", {63'd0, done}, 64'd0);
    chk("midrst_error", {63'd0, error}, 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    base = wr_log.size();
    fr = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h20, 8'h00, 8'h0D, 8'h30, 8'h40, 8'h00, 8'h4E};
    run_frame("postrst", fr);
    chk("postrst_w0", {21'd0, wr_log[base]}, {21'd0, 11'd0, 32'h00200013});
    chk("postrst_w1", {21'd0, wr_log[base+1]}, {21'd0, 11'd1, 32'h0040300D});

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
